// File: rtl/pipelined_lut_activation.sv
// ---------------------------------------------------------------------------
// pipelined_lut_activation
//
// Three-stage LUT + linear-interpolation activation unit with run-time LUT
// loading, a nearest-sample mode and valid/ready flow control.
//
//   S1 : splits the input word into LUT index and fraction, latches mode
//   S2 : reads the base sample and the next sample (clamped at the top)
//   S3 : interpolates (or passes base in nearest mode) into out_a
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset (pipeline and LUT)
//   in_valid   input word present
//   in_ready   unit accepts input this cycle
//   in_z       signed pre-activation value
//   in_mode    0 = interpolate, 1 = nearest (base only)
//   out_valid  output word present
//   out_ready  downstream accepts output
//   out_a      signed activation result
//   cfg_we     LUT write strobe
//   cfg_addr   LUT entry index (offset binary, 0 = most negative sample)
//   cfg_data   signed LUT entry value
// ---------------------------------------------------------------------------
module pipelined_lut_activation #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_z,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data
);

    localparam int FRAC_W = DATA_W - ADDR_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PROD_W = DATA_W + FRAC_W + 2;

    // Inverting the MSB of the two's-complement index field turns it into an
    // offset-binary LUT address.
    localparam logic [ADDR_W-1:0] IDX_FLIP = ADDR_W'(1) << (ADDR_W - 1);
    localparam logic [ADDR_W-1:0] IDX_MAX  = '1;

    logic [DATA_W-1:0] lut [DEPTH];

    logic advance;

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_idx;
    logic [FRAC_W-1:0] s1_rem;
    logic              s1_mode;
    logic [ADDR_W-1:0] s1_idx_next;

    logic              s2_valid;
    logic [DATA_W-1:0] s2_base;
    logic [DATA_W-1:0] s2_next;
    logic [FRAC_W-1:0] s2_rem;
    logic              s2_mode;

    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] diff_x;
    logic signed [PROD_W-1:0] rem_x;
    logic signed [PROD_W-1:0] base_x;
    logic signed [PROD_W-1:0] prod;
    logic        [DATA_W-1:0] result;

    // Single global advance: every stage moves together or holds together.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Top entry has no successor; clamp instead of wrapping to entry 0.
    assign s1_idx_next = (s1_idx == IDX_MAX) ? s1_idx : s1_idx + ADDR_W'(1);

    // LUT storage. Reset restores the identity curve; writes land at the
    // edge, so an S2 read in the same cycle still sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                lut[i] <= DATA_W'((i - DEPTH / 2) * (1 << FRAC_W));
            end
        end else if (cfg_we) begin
            lut[cfg_addr] <= cfg_data;
        end
    end

    // Interpolation on the S2 registers. The result always lies between base
    // and next, so truncating back to DATA_W cannot overflow.
    always_comb begin
        diff   = {s2_next[DATA_W-1], s2_next} - {s2_base[DATA_W-1], s2_base};
        diff_x = {{(PROD_W - DATA_W - 1){diff[DATA_W]}}, diff};
        rem_x  = {{(PROD_W - FRAC_W){1'b0}}, s2_rem};
        base_x = {{(PROD_W - DATA_W){s2_base[DATA_W-1]}}, s2_base};
        prod   = diff_x * rem_x;
        result = s2_mode ? s2_base : DATA_W'(base_x + (prod >>> FRAC_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_idx    <= '0;
            s1_rem    <= '0;
            s1_mode   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_base   <= '0;
            s2_next   <= '0;
            s2_rem    <= '0;
            s2_mode   <= 1'b0;
            out_valid <= 1'b0;
            out_a     <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_idx    <= in_z[DATA_W-1:FRAC_W] ^ IDX_FLIP;
            s1_rem    <= in_z[FRAC_W-1:0];
            s1_mode   <= in_mode;

            // Samples are captured here, so later LUT writes cannot reach a
            // word that has already left S1.
            s2_valid  <= s1_valid;
            s2_base   <= lut[s1_idx];
            s2_next   <= lut[s1_idx_next];
            s2_rem    <= s1_rem;
            s2_mode   <= s1_mode;

            out_valid <= s2_valid;
            if (s2_valid) begin
                out_a <= result;
            end
        end
    end

endmodule
